// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern generator: pattern modes and the
// BOUNCE sweep direction.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/led_pattern_gen.sv
// LED pattern generator: steps an LED vector once per en tick through one of
// four patterns (binary count, rotate, bounce, hold). Mode changes are taken
// only on a tick and reload the pattern seed instead of stepping. wrap pulses
// for one cycle when a step returns the pattern to its seed.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [1:0]           mode,
  output logic [LED_WIDTH-1:0] led,
  output logic                 wrap
);

  localparam logic [LED_WIDTH-1:0] LP_ONE = {{(LED_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LED_WIDTH-1:0] LP_TWO = LP_ONE << 1;
  localparam logic [LED_WIDTH-1:0] LP_MSB = {1'b1, {(LED_WIDTH-1){1'b0}}};
  localparam logic [LED_WIDTH-1:0] LP_ALL = '1;

  logic [LED_WIDTH-1:0] r_led;
  mode_e                r_mode_q;
  dir_e                 r_dir;
  logic                 r_wrap;

  mode_e                w_mode;
  logic                 w_reload;
  logic                 w_step;
  dir_e                 w_dir_nxt;
  logic [LED_WIDTH-1:0] w_led_nxt;
  logic                 w_wrap_nxt;

  assign w_mode   = mode_e'(mode);
  // A tick either reloads (mode changed) or applies exactly one step.
  assign w_reload = en && (w_mode != r_mode_q);
  assign w_step   = en && (w_mode == r_mode_q);

  // Direction state register; reset parks the sweep heading left.
  always_ff @(posedge clk) begin
    if (reset) r_dir <= DIR_LEFT;
    else       r_dir <= w_dir_nxt;
  end

  // Direction next state: forced LEFT on entry to BOUNCE, flips at the ends.
  always_comb begin
    w_dir_nxt = r_dir;
    if (w_reload) begin
      if (w_mode == MODE_BOUNCE) w_dir_nxt = DIR_LEFT;
    end else if (w_step && r_mode_q == MODE_BOUNCE) begin
      if (r_dir == DIR_LEFT && r_led[LED_WIDTH-1]) w_dir_nxt = DIR_RIGHT;
      if (r_dir == DIR_RIGHT && r_led[0])          w_dir_nxt = DIR_LEFT;
    end
  end

  // Step/reload mux and wrap detection for the next LED value.
  always_comb begin
    w_led_nxt  = r_led;
    w_wrap_nxt = 1'b0;
    if (w_reload) begin
      case (w_mode)
        MODE_COUNT:  w_led_nxt = '0;
        MODE_ROTATE: w_led_nxt = LP_ONE;
        MODE_BOUNCE: w_led_nxt = LP_ONE;
        default:     w_led_nxt = r_led;
      endcase
    end else if (w_step) begin
      case (r_mode_q)
        MODE_COUNT: begin
          w_led_nxt  = r_led + LP_ONE;
          w_wrap_nxt = (r_led == LP_ALL);
        end
        MODE_ROTATE: begin
          w_led_nxt  = {r_led[LED_WIDTH-2:0], r_led[LED_WIDTH-1]};
          w_wrap_nxt = (r_led == LP_MSB);
        end
        MODE_BOUNCE: begin
          if (r_dir == DIR_LEFT) begin
            w_led_nxt = r_led[LED_WIDTH-1] ? (r_led >> 1) : (r_led << 1);
          end else begin
            w_led_nxt = r_led[0] ? (r_led << 1) : (r_led >> 1);
          end
          // Period closes when the right-going sweep lands back on bit 0.
          w_wrap_nxt = (r_dir == DIR_RIGHT) && (r_led == LP_TWO);
        end
        default: w_led_nxt = r_led;
      endcase
    end
  end

  // LED, registered mode and wrap pulse; reset wins over a same-edge tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led    <= '0;
      r_mode_q <= MODE_COUNT;
      r_wrap   <= 1'b0;
    end else begin
      r_led  <= w_led_nxt;
      r_wrap <= w_wrap_nxt;
      if (en) r_mode_q <= w_mode;
    end
  end

  assign led  = r_led;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (LED_WIDTH=8). A behavioural model
// tracks the expected led/wrap per cycle (bounce as a phase index over a
// 14-step period) and a compare process checks the DUT every cycle; literal
// checks pin the model at key points.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] led;
  logic       wrap;

  int n_chk  = 0;
  int n_fail = 0;
  int wraps  = 0;

  // model state
  bit         m_ok = 0;
  int         m_mode = 0;
  int         m_led = 0;
  int         m_k = 0;
  bit         m_wrap = 0;

  led_pattern_gen #(.LED_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .led(led), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Behavioural model, updated on each rising edge from the applied inputs.
  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1; m_led = 0; m_mode = 0; m_k = 0; m_wrap = 0;
    end else if (en && int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_wrap = 0;
      if (m_mode == 0) m_led = 0;
      if (m_mode == 1) m_led = 1;
      if (m_mode == 2) begin m_led = 1; m_k = 0; end
    end else if (en) begin
      case (m_mode)
        0: begin m_led = (m_led + 1) % 256; m_wrap = (m_led == 0); end
        1: begin m_led = ((m_led * 2) % 256) + (m_led / 128); m_wrap = (m_led == 1); end
        2: begin
          m_k = (m_k + 1) % 14;
          m_led = 1 << ((m_k <= 7) ? m_k : 14 - m_k);
          m_wrap = (m_k == 0);
        end
        default: m_wrap = 0;
      endcase
    end else begin
      m_wrap = 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      n_chk++;
      if (int'(led) != m_led) begin
        n_fail++;
        $display("FAIL led_model t=%0t got=%02h want=%02h", $time, led, m_led[7:0]);
      end
      n_chk++;
      if (wrap !== m_wrap) begin
        n_fail++;
        $display("FAIL wrap_model t=%0t got=%0b want=%0b", $time, wrap, m_wrap);
      end
      if (wrap === 1'b1) wraps++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // One tick with the given mode, then `gap` idle cycles.
  task automatic tick(input int m, input int gap);
    @(negedge clk); en = 1'b1; mode = 2'(m);
    @(negedge clk); en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_led", int'(led), 0);
    chk("reset_wrap", int'(wrap), 0);

    // COUNT: 256 ticks spaced 4 cycles apart
    wraps = 0;
    for (int i = 0; i < 255; i++) tick(0, 2);
    chk("count_255", int'(led), 255);
    chk("count_nowrap_yet", wraps, 0);
    tick(0, 0);
    chk("count_wrap0", int'(led), 0);
    @(negedge clk);
    chk("count_wraps", wraps, 1);
    for (int i = 0; i < 5; i++) tick(0, 2);
    chk("count_5", int'(led), 5);

    // Mode change gated by en
    @(negedge clk); mode = 2'd1;
    repeat (10) @(negedge clk);
    chk("gate_hold", int'(led), 5);
    wraps = 0;
    tick(1, 1);
    chk("rot_reload", int'(led), 1);

    // ROTATE one full period, then on to 0x10
    for (int i = 0; i < 8; i++) tick(1, 1);
    chk("rot_period", int'(led), 1);
    chk("rot_wraps", wraps, 1);
    for (int i = 0; i < 4; i++) tick(1, 1);
    chk("rot_10", int'(led), 8'h10);

    // HOLD with en streaming high
    wraps = 0;
    @(negedge clk); mode = 2'd3; en = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("hold_led", int'(led), 8'h10);
    chk("hold_wraps", wraps, 0);

    // BOUNCE: reload plus one full period with en held high
    wraps = 0;
    tick(2, 0);
    chk("bnc_reload", int'(led), 1);
    @(negedge clk); en = 1'b1;
    repeat (7) @(negedge clk);
    chk("bnc_top", int'(led), 8'h80);
    repeat (7) @(negedge clk);
    en = 1'b0;
    chk("bnc_back", int'(led), 1);
    @(negedge clk);
    chk("bnc_wraps", wraps, 1);

    // BOUNCE to 0x40 heading right, then reset with a same-edge tick
    for (int i = 0; i < 8; i++) tick(2, 0);
    chk("bnc_40", int'(led), 8'h40);
    @(negedge clk); reset = 1'b1; en = 1'b1; mode = 2'd2;
    @(negedge clk); reset = 1'b0; en = 1'b0;
    chk("rst_prio_led", int'(led), 0);
    chk("rst_prio_wrap", int'(wrap), 0);
    // mode_q must be COUNT: a COUNT tick steps rather than reloads
    tick(0, 1);
    chk("rst_modeq_count", int'(led), 1);

    // Short stream in COUNT
    @(negedge clk); en = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("count_stream", int'(led), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
